video_out_adapter: RTL
======================

Name: video_out_adapter

Overview:
- Parametrised successor to the ad-hoc video glue in the Athena top level.
- Turns raw arcade-core video (R/G/B, blanks, syncs, CE_PIXEL), all on the core clock, into registered Pocket video-interface signals: rgb, de, hs, vs, skip.
- Generalised for colour depth, sync polarity, CE stretch length and colour expansion mode.
- Adds line-width/frame-height measurement so firmware and the bench can check core timing.

Parameters:
- IN_BITS, 4, bits per colour channel from the core (1..8).
- EXPAND_REPLICATE, 1, 1 = MSB bit-replication to 8 bits; 0 = zero-pad LSBs.
- SYNC_ACTIVE_HIGH, 1, polarity of the core hsync/vsync inputs.
- CE_STRETCH, 2, cycles a ce_pixel pulse is held for skip generation (1..8).
- CNT_W, 12, width of the measurement counters.

Ports:
- clk, in, 1, core clock; all logic in this domain.
- reset_n, in, 1, asynchronous active-low reset.
- r_in, in, IN_BITS, core red.
- g_in, in, IN_BITS, core green.
- b_in, in, IN_BITS, core blue.
- hblank, in, 1, core horizontal blank.
- vblank, in, 1, core vertical blank.
- hsync, in, 1, core hsync.
- vsync, in, 1, core vsync.
- ce_pixel, in, 1, core pixel enable.
- rgb, out, 24, {R8,G8,B8} to video_if.
- de, out, 1, data enable.
- hs, out, 1, one-cycle hsync pulse.
- vs, out, 1, one-cycle vsync pulse.
- skip, out, 1, de with no pixel this cycle.
- line_width, out, CNT_W, active pixels in the last complete line.
- frame_lines, out, CNT_W, active lines in the last complete frame.
- measure_valid, out, 1, a complete frame has been measured.

Behaviour:
- Reset (async assert, sync release): all outputs 0; counters, CE history and sync history cleared.
- Latency: every video output is registered, 1 cycle after its inputs.
- de_c = ~(hblank | vblank); de <= de_c.
- ce_held = ce_pixel | OR of the previous CE_STRETCH-1 ce_pixel samples (shift register). With CE_STRETCH=1, ce_held = ce_pixel.
- skip <= de_c & ~ce_held.
- rgb <= de_c ? {exp(r_in), exp(g_in), exp(b_in)} : 24'h0.
- exp() with EXPAND_REPLICATE=1: the input pattern repeated and truncated to the top 8 bits. Example: 4'hA -> 8'hAA; 3'b101 -> 8'b10110110.
- exp() with EXPAND_REPLICATE=0: {in, zeros}.
- IN_BITS=8 passes through unchanged in both modes.
- Sync: active = SYNC_ACTIVE_HIGH ? sync : ~sync. hs <= active & ~active_prev, i.e. exactly one cycle per active edge. vs is derived identically from vsync.
- Sync held active across reset release: no pulse, because active_prev resets to 1-equivalent (the inactive-to-active edge must actually be observed).
- h_cnt:
  - increments on ce_pixel & de_c;
  - saturates at 2^CNT_W-1, no wrap;
  - on a de_c falling edge: line_width <= h_cnt and h_cnt <= 0.
  - If ce_pixel & de_c coincide with nothing else, it is counted before the latch.
- v_cnt:
  - increments on each de_c falling edge that ends a line with h_cnt != 0;
  - saturates like h_cnt;
  - on the vs pulse cycle: frame_lines <= v_cnt and v_cnt <= 0.
  - A de_c falling edge on the same cycle as the vs pulse is counted into the latched value.
- measure_valid: set on the first vs pulse after at least one counted line; stays set until reset.

Optional Feature:
- Macro: VIDEO_OUT_ADAPTER_TESTPAT_EN.
- When defined: input test_pat_en (1 bit) is added. While it is 1, rgb in de is replaced by 8 vertical colour bars; bar index = h_cnt[CNT_W-1 -: 3] scaled against the last line_width, or h_cnt[6:4] when measure_valid = 0. Bar order: white, yellow, cyan, green, magenta, red, blue, black (components 8'hFF/8'h00). de/skip/hs/vs are unchanged.
- When undefined: no port, no logic.

Decomposition:
- Package video_pkg: rgb24_t struct {r,g,b}; function expand_channel(in, bits, replicate); bar colour constant array.
- Sub-module video_pulse_gen (polarity-parameterised one-shot edge pulse), instantiated twice for hs and vs.

Test Plan:
- IN_BITS=4, replicate, de_c=1, r/g/b=A/5/F -> rgb=24'hAA55FF next cycle. Same stimulus with EXPAND_REPLICATE=0 -> 24'hA050F0.
- hblank=1 with colour 4'hF -> rgb=0, de=0, skip=0.
- ce_pixel every 4th cycle, CE_STRETCH=2, de_c=1 -> skip pattern 0,0,1,1 repeating. With CE_STRETCH=1 -> 0,1,1,1.
- hsync low-to-high held 10 cycles, SYNC_ACTIVE_HIGH=1 -> hs high exactly 1 cycle. SYNC_ACTIVE_HIGH=0 -> pulse on the falling edge instead.
- Frame of 224 lines x 256 CE-pixels, then vsync -> line_width=256, frame_lines=224, measure_valid=1. Lines of 5000 pixels with CNT_W=12 -> line_width=4095.
- Reset asserted mid-line -> all outputs 0 immediately. After release with vsync already active -> no vs pulse; measure_valid=0 until the next full frame.

Source files
------------

// File: rtl/video_out_adapter_pkg.sv
// Shared types and helpers for the video output adapter: 24-bit pixel
// struct, channel expansion to 8 bits, and the test-pattern bar colours.
package video_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  // Bar order left to right: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [0:7][23:0] BAR_RGB = {
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  // Widen a channel held in the low 'bits' of chan to 8 bits, either by
  // repeating the pattern from the MSB down or by padding zeros below it.
  function automatic logic [7:0] expand_channel(input logic [7:0] chan,
                                                input int bits,
                                                input logic replicate);
    logic [7:0] res;
    int idx;
    res = '0;
    if (bits >= 8) begin
      res = chan;
    end else if (bits < 1) begin
      res = '0;
    end else if (replicate) begin
      for (int i = 0; i < 8; i++) begin
        idx = bits - 1 - ((7 - i) % bits);
        res[3'(i)] = chan[3'(idx)];
      end
    end else begin
      res = chan << (8 - bits);
    end
    return res;
  endfunction

endpackage

// File: rtl/video_out_adapter_pulse_gen.sv
// One-shot pulse on the inactive-to-active edge of a sync input. The
// history flop resets to "active" so a sync already asserted when reset
// releases does not produce a pulse.
module video_pulse_gen #(
  parameter bit ACTIVE_HIGH = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sync,
  output logic pulse
);

  logic active;
  logic active_prev;

  assign active = ACTIVE_HIGH ? sync : ~sync;

  // Register the edge detect and remember the previous active level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_prev <= 1'b1;
      pulse       <= 1'b0;
    end else begin
      active_prev <= active;
      pulse       <= active & ~active_prev;
    end
  end

endmodule

// File: rtl/video_out_adapter.sv
// Arcade-core video to Pocket video-interface adapter. Registers colour,
// data enable, skip and one-shot syncs, and measures active line width and
// frame height in core pixels/lines.
// Optional: VIDEO_OUT_ADAPTER_TESTPAT_EN adds test_pat_en, which replaces
// active video with eight vertical colour bars.
module video_out_adapter
  import video_pkg::*;
#(
  parameter int IN_BITS          = 4,
  parameter int EXPAND_REPLICATE = 1,
  parameter int SYNC_ACTIVE_HIGH = 1,
  parameter int CE_STRETCH       = 2,
  parameter int CNT_W            = 12
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [IN_BITS-1:0] r_in,
  input  logic [IN_BITS-1:0] g_in,
  input  logic [IN_BITS-1:0] b_in,
  input  logic               hblank,
  input  logic               vblank,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               ce_pixel,
`ifdef VIDEO_OUT_ADAPTER_TESTPAT_EN
  input  logic               test_pat_en,
`endif
  output logic [23:0]        rgb,
  output logic               de,
  output logic               hs,
  output logic               vs,
  output logic               skip,
  output logic [CNT_W-1:0]   line_width,
  output logic [CNT_W-1:0]   frame_lines,
  output logic               measure_valid
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             de_c;
  logic             ce_held;
  rgb24_t           pix_exp;
  logic [23:0]      pix;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [CNT_W-1:0] v_next;
  logic             de_fall;
  logic             line_end;

  assign de_c = ~(hblank | vblank);

  assign pix_exp.r = expand_channel(8'(r_in), IN_BITS, EXPAND_REPLICATE != 0);
  assign pix_exp.g = expand_channel(8'(g_in), IN_BITS, EXPAND_REPLICATE != 0);
  assign pix_exp.b = expand_channel(8'(b_in), IN_BITS, EXPAND_REPLICATE != 0);

  generate
    if (CE_STRETCH > 1) begin : g_stretch
      logic [CE_STRETCH-2:0] ce_hist;

      // Keep the last CE_STRETCH-1 ce_pixel samples
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ce_hist <= '0;
        else          ce_hist <= (CE_STRETCH-1)'({ce_hist, ce_pixel});
      end

      assign ce_held = ce_pixel | (|ce_hist);
    end else begin : g_no_stretch
      assign ce_held = ce_pixel;
    end
  endgenerate

`ifdef VIDEO_OUT_ADAPTER_TESTPAT_EN
  logic [2:0] bar;

  // Bar index: position within the last measured line in eighths, or a
  // fixed 16-pixel bar width until a frame has been measured
  always_comb begin
    bar = h_cnt[6:4];
    if (measure_valid) begin
      bar = 3'd0;
      for (int k = 1; k < 8; k++) begin
        if ({h_cnt, 3'b000} >= (CNT_W+3)'(k) * {3'b000, line_width}) bar = 3'(k);
      end
    end
  end

  assign pix = test_pat_en ? BAR_RGB[bar] : pix_exp;
`else
  assign pix = pix_exp;
`endif

  // Registered video outputs; colour forced to black outside active video
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb  <= '0;
      de   <= 1'b0;
      skip <= 1'b0;
    end else begin
      rgb  <= de_c ? pix : 24'h0;
      de   <= de_c;
      skip <= de_c & ~ce_held;
    end
  end

  video_pulse_gen #(.ACTIVE_HIGH(SYNC_ACTIVE_HIGH != 0)) u_hs_pulse (
    .clk     (clk),
    .reset_n (reset_n),
    .sync    (hsync),
    .pulse   (hs)
  );

  video_pulse_gen #(.ACTIVE_HIGH(SYNC_ACTIVE_HIGH != 0)) u_vs_pulse (
    .clk     (clk),
    .reset_n (reset_n),
    .sync    (vsync),
    .pulse   (vs)
  );

  // de holds last cycle's de_c, so this is the end of an active run
  assign de_fall  = de & ~de_c;
  assign line_end = de_fall & (h_cnt != '0);
  assign v_next   = (line_end && (v_cnt != CNT_MAX)) ? v_cnt + 1'b1 : v_cnt;

  // Pixel counter: saturating count of enabled active pixels, latched at line end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt      <= '0;
      line_width <= '0;
    end else if (de_fall) begin
      line_width <= h_cnt;
      h_cnt      <= '0;
    end else if (ce_pixel && de_c && (h_cnt != CNT_MAX)) begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Line counter: a line ending on the vs cycle is included in the latch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_cnt         <= '0;
      frame_lines   <= '0;
      measure_valid <= 1'b0;
    end else if (vs) begin
      frame_lines <= v_next;
      v_cnt       <= '0;
      if (v_next != '0) measure_valid <= 1'b1;
    end else begin
      v_cnt <= v_next;
    end
  end

endmodule
